// File: rtl/bp_axil_nbf_host_if.sv
// AXI-Lite bundle between the NBF loader (master) and the NBF host bridge (slave).
interface bp_axil_nbf_host_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [2:0]              awprot;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [2:0]              arprot;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, arprot, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, arprot, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bp_axil_nbf_host.sv
// AXI-Lite slave: packs five data-port writes into one 136-bit NBF command and
// buffers host read responses in a FIFO polled through count/data registers.
module bp_axil_nbf_host #(
    parameter int S_AXIL_ADDR_WIDTH = 64,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int resp_els_p        = 8
) (
    input  logic                     m_axil_aclk,
    input  logic                     reset,
    bp_axil_nbf_host_if.slave        s_axil,
    output logic [135:0]             nbf_o,
    output logic                     nbf_v_o,
    input  logic                     nbf_ready_i,
    input  logic [31:0]              resp_data_i,
    input  logic                     resp_v_i,
    output logic                     resp_ready_o
);
    localparam int DW    = S_AXIL_DATA_WIDTH;
    localparam int PTR_W = $clog2(resp_els_p);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(resp_els_p);

    localparam logic [7:0] ADDR_NBF  = 8'h00;
    localparam logic [7:0] ADDR_CNT  = 8'h10;
    localparam logic [7:0] ADDR_DATA = 8'h14;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic [7:0]       waddr;
    logic [7:0]       raddr;
    logic             wr_nbf;
    logic             wr_go;
    logic             rd_go;
    logic             push;
    logic             pop;
    logic [2:0]       word_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      mem [resp_els_p];
    logic             unused_bits;

    assign waddr  = s_axil.awaddr[7:0];
    assign raddr  = s_axil.araddr[7:0];
    assign wr_nbf = (waddr == ADDR_NBF);

    // A finished command must drain before another data word can overwrite it.
    assign s_axil.awready = ~reset & s_axil.awvalid & s_axil.wvalid & ~s_axil.bvalid
                          & ~(wr_nbf & nbf_v_o);
    assign s_axil.wready  = s_axil.awready;
    assign wr_go          = s_axil.awready;

    assign s_axil.arready = ~reset & ~s_axil.rvalid;
    assign rd_go          = s_axil.arvalid & s_axil.arready;

    assign resp_ready_o = (count != FULL_CNT);
    assign push         = resp_v_i & resp_ready_o;
    assign pop          = rd_go & (raddr == ADDR_DATA) & (count != '0);

    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.wstrb,
                           s_axil.awaddr[S_AXIL_ADDR_WIDTH-1:8],
                           s_axil.araddr[S_AXIL_ADDR_WIDTH-1:8]};

    // NOTE: FIFO storage has no reset; occupancy is tracked by count, so stale words are never observed.
    always_ff @(posedge m_axil_aclk) begin
        if (push) mem[wr_ptr] <= resp_data_i;
    end

    // NOTE: all state uses non-blocking assignments, so a later assignment in this block
    // overrides an earlier one in the same cycle (e.g. a new accept beats a handshake clear).
    always_ff @(posedge m_axil_aclk) begin
        if (reset) begin
            s_axil.bvalid <= 1'b0;
            s_axil.bresp  <= RESP_OKAY;
            s_axil.rvalid <= 1'b0;
            s_axil.rdata  <= '0;
            s_axil.rresp  <= RESP_OKAY;
            nbf_v_o       <= 1'b0;
            nbf_o         <= '0;
            word_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            if (s_axil.bvalid && s_axil.bready) s_axil.bvalid <= 1'b0;
            if (wr_go) begin
                s_axil.bvalid <= 1'b1;
                s_axil.bresp  <= wr_nbf ? RESP_OKAY : RESP_SLVERR;
            end

            if (nbf_v_o && nbf_ready_i) nbf_v_o <= 1'b0;
            if (wr_go && wr_nbf) begin
                case (word_cnt)
                    3'd0:    nbf_o[31:0]    <= s_axil.wdata[31:0];
                    3'd1:    nbf_o[63:32]   <= s_axil.wdata[31:0];
                    3'd2:    nbf_o[95:64]   <= s_axil.wdata[31:0];
                    3'd3:    nbf_o[127:96]  <= s_axil.wdata[31:0];
                    3'd4:    nbf_o[135:128] <= s_axil.wdata[7:0];
                    default: ;
                endcase
                if (word_cnt == 3'd4) begin
                    word_cnt <= '0;
                    nbf_v_o  <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 3'd1;
                end
            end

            if (s_axil.rvalid && s_axil.rready) s_axil.rvalid <= 1'b0;
            if (rd_go) begin
                s_axil.rvalid <= 1'b1;
                case (raddr)
                    ADDR_CNT: begin
                        s_axil.rdata <= DW'(count);
                        s_axil.rresp <= RESP_OKAY;
                    end
                    ADDR_DATA: begin
                        s_axil.rdata <= (count != '0) ? mem[rd_ptr] : '0;
                        s_axil.rresp <= RESP_OKAY;
                    end
                    default: begin
                        s_axil.rdata <= '0;
                        s_axil.rresp <= RESP_SLVERR;
                    end
                endcase
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
